tree_stage_pipe: RTL and testbench
==================================

// Module: tree_stage_pipe
// PURPOSE
// - Parametrised successor of the fixed tree-cell stage. One tree level per instance; instances chain level-to-level.
// - Each instance holds a programmable node table: per node, a feature index plus a threshold.
// - Run mode: selects one feature from the incoming sample, compares it with the node threshold, and emits a child index one bit wider.
// - Adds valid/ready backpressure, a node-valid table, busy/error reporting, and a runtime-selectable feature per node.
// PARAMETERS
// - STAGE       1   tree level; node index width = STAGE; table depth = 2**STAGE entries
// - FEAT_W      32  width of one feature and of the threshold
// - NUM_FEAT    8   features per sample; sample width = NUM_FEAT*FEAT_W
// - PIPE_DEPTH  4   register stages before the compare stage; legal range 2..8
// - FSEL_W      3   feature-select width; must equal clog2(NUM_FEAT)
// PORTS
// - clk        in   1                  clock
// - rst        in   1                  synchronous active-high reset
// - cfg_mode   in   1                  1 = configure, 0 = run
// - cfg_wr     in   1                  table write strobe
// - cfg_node   in   STAGE              node to write
// - cfg_fsel   in   FSEL_W             feature index for that node
// - cfg_thr    in   FEAT_W             threshold for that node
// - cfg_err    out  1                  1-cycle pulse: write rejected
// - busy       out  1                  any pipeline stage holds valid data
// - in_valid   in   1                  input sample/node valid
// - in_ready   out  1                  stage can accept input
// - in_sample  in   NUM_FEAT*FEAT_W    sample; feature k = bits [k*FEAT_W +: FEAT_W]
// - in_node    in   STAGE              node index at this level
// - out_valid  out  1                  output valid
// - out_ready  in   1                  downstream ready
// - out_sample out  NUM_FEAT*FEAT_W    sample, passed through unchanged
// - out_node   out  STAGE+1            child index = {node, dir}
// - out_miss   out  1                  node was unprogrammed; dir forced to 0
// BEHAVIOUR
// - Reset:
//   - All stage valid bits = 0; all node-valid bits = 0.
//   - out_valid = 0, out_node = 0, out_miss = 0, cfg_err = 0, busy = 0.
//   - out_sample = 0. Table data RAM is not reset.
// - Handshake:
//   - stall = out_valid & ~out_ready. in_ready = ~stall & ~cfg_mode.
//   - Transfer occurs when valid & ready are both high.
//   - On stall, every stage holds. No bubble-collapse.
//   - out_* stay stable while out_valid = 1 and out_ready = 0.
// - Latency: PIPE_DEPTH+1 cycles from input transfer to out_valid, when there is no stall. Throughput is 1 per cycle.
// - Table read:
//   - Address = node index held in stage PIPE_DEPTH-1. Synchronous read, 1 cycle; data aligns with the compare stage.
//   - The read enable advances only with the pipeline. A stall must not corrupt the aligned entry.
// - Compare stage:
//   - f = feature[fsel]. dir = (f >= thr), unsigned.
//   - out_node = {node, dir}.
//   - If the node-valid bit is 0: dir = 0 and out_miss = 1.
// - Writes:
//   - Accepted only when cfg_mode=1, cfg_wr=1 and busy=0. An accepted write sets that node's valid bit.
//   - cfg_wr while busy=1 or cfg_mode=0: write is dropped and cfg_err pulses for 1 cycle.
//   - Rewriting a node overwrites it; last write wins.
// - Mode switch mid-flight:
//   - Raising cfg_mode blocks new input only.
//   - In-flight samples drain normally under out_ready.
// - Reset mid-operation: in-flight samples are discarded and the node table is invalidated. Reprogramming is required.
// CONFIGURATION
// - Macro: TREE_STAGE_PERF_CNT_EN.
// - Defined:
//   - Adds outputs perf_samples (32) and perf_right (32).
//   - perf_samples counts output transfers; perf_right counts transfers with dir=1.
//   - Both cleared by rst; both wrap at 2**32-1 -> 0.
//   - Both also cleared by cfg_wr accepted to node 0.
// - Undefined: the ports and counters are absent. Datapath behaviour is identical.
// TESTING
// - Config and compare:
//   - Stimulus: STAGE=2; node 1 = {fsel=3, thr=100}; send in_node=1 with feature3=100, then feature3=99.
//   - Response: out_node=3'b011 then 3'b010, each PIPE_DEPTH+1 cycles after input.
// - Unprogrammed node:
//   - Stimulus: send in_node=2 after reset, with no writes.
//   - Response: out_node=3'b100, out_miss=1.
// - Backpressure:
//   - Stimulus: stream 10 samples; hold out_ready=0 for 5 cycles mid-stream.
//   - Response: in_ready=0 during the stall; outputs are held stable; all 10 emerge in order with no loss or duplication.
// - Write while busy:
//   - Stimulus: cfg_mode=1 with 2 samples in flight; pulse cfg_wr.
//   - Response: cfg_err=1 for 1 cycle; the table is unchanged; the in-flight samples complete.
// - Reset mid-flight:
//   - Stimulus: assert rst for 1 cycle with 3 samples in flight.
//   - Response: out_valid=0 the next cycle; busy=0; a previously programmed node reports out_miss=1.
// - TREE_STAGE_PERF_CNT_EN:
//   - Stimulus: 6 samples, 4 of them going right.
//   - Response: perf_samples=6, perf_right=4; a preloaded count of 2**32-1 wraps to 0.

Source files
------------

// File: rtl/tree_stage_pipe.sv
// ---------------------------------------------------------------------------
// tree_stage_pipe
// One level of a decision-tree classifier. Each node in this level has a
// programmable feature select and threshold. An incoming sample moves through
// PIPE_DEPTH register stages. The node entry for the sample is read in step
// with the pipeline. At the output stage the selected feature is compared
// with the threshold, giving the child index {node, dir}.
//
// Optional feature macro: TREE_STAGE_PERF_CNT_EN
//   When defined, the block adds the perf_samples and perf_right counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_mode                 1 = configure (input blocked), 0 = run
//   cfg_wr/node/fsel/thr     node-table write; accepted only while idle
//   cfg_err                  1-cycle pulse when a write is rejected
//   busy                     any pipeline stage holds valid data
//   in_valid/ready/sample/node   upstream handshake and payload
//   out_valid/ready/sample/node  downstream handshake; out_node = {node, dir}
//   out_miss                 node was unprogrammed (dir forced to 0)
//   perf_samples/perf_right  output transfers / transfers that went right
// ---------------------------------------------------------------------------
module tree_stage_pipe #(
    parameter int STAGE      = 1,
    parameter int FEAT_W     = 32,
    parameter int NUM_FEAT   = 8,
    parameter int PIPE_DEPTH = 4,
    parameter int FSEL_W     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_mode,
    input  logic                         cfg_wr,
    input  logic [STAGE-1:0]             cfg_node,
    input  logic [FSEL_W-1:0]            cfg_fsel,
    input  logic [FEAT_W-1:0]            cfg_thr,
    output logic                         cfg_err,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FEAT*FEAT_W-1:0]   in_sample,
    input  logic [STAGE-1:0]             in_node,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FEAT*FEAT_W-1:0]   out_sample,
    output logic [STAGE:0]               out_node,
    output logic                         out_miss
`ifdef TREE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_samples,
    output logic [31:0]                  perf_right
`endif
);

    localparam int SW    = NUM_FEAT * FEAT_W;
    localparam int DEPTH = 2 ** STAGE;

    logic [PIPE_DEPTH-1:0] s_valid;
    logic [SW-1:0]         s_sample [PIPE_DEPTH];
    logic [STAGE-1:0]      s_node   [PIPE_DEPTH];

    logic                  o_valid;
    logic [SW-1:0]         o_sample;
    logic [STAGE-1:0]      o_node;

    // Node entry read alongside the last stage; it lands with the output stage.
    logic                  e_valid;
    logic [FSEL_W-1:0]     e_fsel;
    logic [FEAT_W-1:0]     e_thr;

    logic [FSEL_W-1:0]     fsel_mem [DEPTH];
    logic [FEAT_W-1:0]     thr_mem  [DEPTH];
    logic [DEPTH-1:0]      node_valid;

    logic                  stall;
    logic                  adv;
    logic                  wr_ok;
    logic                  dir;
    logic [FEAT_W-1:0]     feat;

    assign stall    = o_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall & ~cfg_mode;
    assign busy     = (|s_valid) | o_valid;
    assign wr_ok    = cfg_mode & cfg_wr & ~busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid    <= '0;
            o_valid    <= 1'b0;
            o_sample   <= '0;
            o_node     <= '0;
            e_valid    <= 1'b0;
            node_valid <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_wr & ~wr_ok;
            if (wr_ok) begin
                node_valid[cfg_node] <= 1'b1;
            end
            if (adv) begin
                s_valid  <= {s_valid[PIPE_DEPTH-2:0], in_valid & in_ready};
                o_valid  <= s_valid[PIPE_DEPTH-1];
                o_sample <= s_sample[PIPE_DEPTH-1];
                o_node   <= s_node[PIPE_DEPTH-1];
                // Gating with the stage valid keeps the miss/dir path quiet on bubbles.
                e_valid  <= s_valid[PIPE_DEPTH-1] & node_valid[s_node[PIPE_DEPTH-1]];
            end
        end
    end

    // Payload and table storage carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            fsel_mem[cfg_node] <= cfg_fsel;
            thr_mem[cfg_node]  <= cfg_thr;
        end
        if (adv) begin
            s_sample[0] <= in_sample;
            s_node[0]   <= in_node;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                s_sample[i] <= s_sample[i-1];
                s_node[i]   <= s_node[i-1];
            end
            e_fsel <= fsel_mem[s_node[PIPE_DEPTH-1]];
            e_thr  <= thr_mem[s_node[PIPE_DEPTH-1]];
        end
    end

    always_comb begin
        feat = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (e_fsel == FSEL_W'(k)) begin
                feat = o_sample[k*FEAT_W +: FEAT_W];
            end
        end
    end

    assign dir        = e_valid & (feat >= e_thr);
    assign out_valid  = o_valid;
    assign out_sample = o_sample;
    assign out_node   = {o_node, dir};
    assign out_miss   = o_valid & ~e_valid;

`ifdef TREE_STAGE_PERF_CNT_EN
    // A write that reaches node 0 restarts the statistics for a new table.
    always_ff @(posedge clk) begin
        if (rst || (wr_ok && (cfg_node == '0))) begin
            perf_samples <= '0;
            perf_right   <= '0;
        end else if (o_valid && out_ready) begin
            perf_samples <= perf_samples + 32'd1;
            if (dir) begin
                perf_right <= perf_right + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tree_stage_pipe.sv
module tb_tree_stage_pipe;
    localparam int STAGE    = 2;
    localparam int FEAT_W   = 32;
    localparam int NUM_FEAT = 8;
    localparam int PD       = 4;
    localparam int FSEL_W   = 3;
    localparam int SW       = NUM_FEAT * FEAT_W;
    localparam int LAT      = PD + 1;

    typedef struct packed {
        logic [SW-1:0]  sample;
        logic [STAGE:0] node;
        logic           miss;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_mode = 1'b0, cfg_wr = 1'b0;
    logic [STAGE-1:0]  cfg_node = '0;
    logic [FSEL_W-1:0] cfg_fsel = '0;
    logic [FEAT_W-1:0] cfg_thr = '0;
    logic              cfg_err, busy;
    logic              in_valid = 1'b0, in_ready;
    logic [SW-1:0]     in_sample = '0;
    logic [STAGE-1:0]  in_node = '0;
    logic              out_valid, out_ready = 1'b1;
    logic [SW-1:0]     out_sample;
    logic [STAGE:0]    out_node;
    logic              out_miss;
`ifdef TREE_STAGE_PERF_CNT_EN
    logic [31:0]       perf_samples, perf_right;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Reference table as the bench believes it is programmed.
    int                m_fsel [4];
    logic [FEAT_W-1:0] m_thr  [4];
    bit                m_valid[4];

    always #5 clk = ~clk;

    tree_stage_pipe #(
        .STAGE(STAGE), .FEAT_W(FEAT_W), .NUM_FEAT(NUM_FEAT),
        .PIPE_DEPTH(PD), .FSEL_W(FSEL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_mode(cfg_mode), .cfg_wr(cfg_wr), .cfg_node(cfg_node),
        .cfg_fsel(cfg_fsel), .cfg_thr(cfg_thr), .cfg_err(cfg_err), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample), .in_node(in_node),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
        .out_node(out_node), .out_miss(out_miss)
`ifdef TREE_STAGE_PERF_CNT_EN
        , .perf_samples(perf_samples), .perf_right(perf_right)
`endif
    );

    function automatic exp_t model(input logic [SW-1:0] s, input int n);
        exp_t e;
        logic [FEAT_W-1:0] f;
        logic [STAGE-1:0] nb;
        f = s[m_fsel[n]*FEAT_W +: FEAT_W];
        nb = STAGE'(n);
        e.sample = s;
        e.miss = !m_valid[n];
        e.node = {nb, (m_valid[n] && (f >= m_thr[n])) ? 1'b1 : 1'b0};
        return e;
    endfunction

    function automatic logic [SW-1:0] rnd_sample(input int n);
        logic [SW-1:0] s;
        logic [FEAT_W-1:0] t;
        for (int k = 0; k < NUM_FEAT; k++) s[k*FEAT_W +: FEAT_W] = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            t = m_thr[n] + FEAT_W'($urandom_range(0, 2));
            t = t - 32'd1;
            s[m_fsel[n]*FEAT_W +: FEAT_W] = t;
        end
        return s;
    endfunction

    function automatic logic [SW-1:0] with_feat(input int k, input logic [FEAT_W-1:0] v);
        logic [SW-1:0] s;
        for (int j = 0; j < NUM_FEAT; j++) s[j*FEAT_W +: FEAT_W] = $urandom;
        s[k*FEAT_W +: FEAT_W] = v;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_write(input int n, input int fs, input logic [FEAT_W-1:0] th);
        cfg_node = STAGE'(n); cfg_fsel = FSEL_W'(fs); cfg_thr = th; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic send_one(input logic [SW-1:0] s, input int n, output int lat,
                            output logic [STAGE:0] onode, output logic omiss,
                            output logic [SW-1:0] osamp);
        in_sample = s; in_node = STAGE'(n); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; lat = 1;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        onode = out_node; omiss = out_miss; osamp = out_sample;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_node !== 3'b000) begin n_fail++; $display("FAIL reset_out_node got %b want 000", out_node); end
        n_cmp++; if (out_miss !== 1'b0) begin n_fail++; $display("FAIL reset_out_miss got %b want 0", out_miss); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (out_sample !== '0) begin n_fail++; $display("FAIL reset_out_sample got %h want 0", out_sample); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    task automatic test_unprogrammed();
        int lat; logic [STAGE:0] on; logic om; logic [SW-1:0] os; logic [SW-1:0] s;
        s = with_feat(0, 32'hFFFF_FFFF);
        send_one(s, 2, lat, on, om, os);
        n_cmp++; if (lat !== LAT) begin n_fail++; $display("FAIL unprog_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (on !== 3'b100) begin n_fail++; $display("FAIL unprog_node got %b want 100", on); end
        n_cmp++; if (om !== 1'b1) begin n_fail++; $display("FAIL unprog_miss got %b want 1", om); end
    endtask

    task automatic test_config_compare();
        int lat; logic [STAGE:0] on; logic om; logic [SW-1:0] os; logic [SW-1:0] s;
        cfg_mode = 1'b1; #1;
        do_write(1, 3, 32'd100);
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_ok_err got %b want 0", cfg_err); end
        cfg_mode = 1'b0;
        m_fsel[1] = 3; m_thr[1] = 32'd100; m_valid[1] = 1'b1;
        tick();
        s = with_feat(3, 32'd100);
        send_one(s, 1, lat, on, om, os);
        n_cmp++; if (lat !== LAT) begin n_fail++; $display("FAIL cmp_eq_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (on !== 3'b011) begin n_fail++; $display("FAIL cmp_eq_node got %b want 011", on); end
        n_cmp++; if (om !== 1'b0) begin n_fail++; $display("FAIL cmp_eq_miss got %b want 0", om); end
        n_cmp++; if (os !== s) begin n_fail++; $display("FAIL cmp_eq_sample got %h want %h", os, s); end
        s = with_feat(3, 32'd99);
        send_one(s, 1, lat, on, om, os);
        n_cmp++; if (lat !== LAT) begin n_fail++; $display("FAIL cmp_lt_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (on !== 3'b010) begin n_fail++; $display("FAIL cmp_lt_node got %b want 010", on); end
    endtask

    task automatic test_write_busy();
        exp_t q[$]; exp_t e; int got; int lat;
        logic [STAGE:0] on; logic om; logic [SW-1:0] os; logic [SW-1:0] s;
        got = 0;
        for (int i = 0; i < 2; i++) begin
            s = rnd_sample(1);
            in_sample = s; in_node = 2'd1; in_valid = 1'b1;
            q.push_back(model(s, 1));
            tick();
        end
        in_valid = 1'b0; cfg_mode = 1'b1; #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wbusy_busy got %b want 1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wbusy_in_ready got %b want 0", in_ready); end
        do_write(1, 0, 32'd0);
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL wbusy_err_pulse got %b want 1", cfg_err); end
        tick();
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL wbusy_err_width got %b want 0", cfg_err); end
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (out_valid) begin
                e = q.pop_front(); got++;
                n_cmp++;
                if (out_node !== e.node || out_miss !== e.miss || out_sample !== e.sample) begin
                    n_fail++; $display("FAIL wbusy_drain got %b/%b want %b/%b", out_node, out_miss, e.node, e.miss);
                end
            end
            tick();
        end
        n_cmp++; if (got !== 2) begin n_fail++; $display("FAIL wbusy_drain_count got %0d want 2", got); end
        cfg_mode = 1'b0; tick();
        s = with_feat(3, 32'd99);
        send_one(s, 1, lat, on, om, os);
        n_cmp++; if (on !== 3'b010) begin n_fail++; $display("FAIL wbusy_table_kept got %b want 010", on); end
        do_write(2, 1, 32'd5);
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL wrun_err got %b want 1", cfg_err); end
        tick();
        send_one(with_feat(1, 32'd50), 2, lat, on, om, os);
        n_cmp++; if (om !== 1'b1 || on !== 3'b100) begin n_fail++; $display("FAIL wrun_dropped got %b/%b want 100/1", on, om); end
    endtask

    task automatic test_reset_midflight();
        logic seen; int lat; logic [STAGE:0] on; logic om; logic [SW-1:0] os;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_sample = rnd_sample(1); in_node = 2'd1; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        for (int c = 0; c < 8; c++) begin if (out_valid) seen = 1'b1; tick(); end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard got %b want 0", seen); end
        send_one(with_feat(3, 32'd200), 1, lat, on, om, os);
        n_cmp++; if (on !== 3'b010 || om !== 1'b1) begin n_fail++; $display("FAIL rstmid_invalid got %b/%b want 010/1", on, om); end
    endtask

    task automatic program_random();
        cfg_mode = 1'b1; #1;
        for (int n = 0; n < 4; n++) begin
            if (n != 2) begin
                m_fsel[n] = $urandom_range(0, NUM_FEAT-1);
                m_thr[n] = $urandom;
                do_write(n, m_fsel[n], m_thr[n]);
                m_valid[n] = 1'b1;
            end
        end
        cfg_mode = 1'b0; tick();
    endtask

    // fixed_stall: continuous input, out_ready low for cycles 6..10.
    task automatic test_stream(input int n, input bit fixed_stall);
        exp_t q[$]; exp_t e; exp_t held; bit was_stall; bit extra;
        int sent, got, cyc, nd; logic exp_ir;
        sent = 0; got = 0; cyc = 0; was_stall = 1'b0; extra = 1'b0;
        while (got < n && cyc < 2000) begin
            nd = $urandom_range(0, 3);
            in_node = STAGE'(nd);
            in_sample = rnd_sample(nd);
            in_valid = (sent < n) && (fixed_stall || $urandom_range(0, 1) == 1);
            out_ready = fixed_stall ? !(cyc >= 6 && cyc < 11) : ($urandom_range(0, 3) != 0);
            #1;
            if (was_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_node !== held.node || out_miss !== held.miss || out_sample !== held.sample) begin
                    n_fail++; $display("FAIL stall_hold cyc %0d got %b/%b want %b/%b", cyc, out_node, out_miss, held.node, held.miss);
                end
            end
            exp_ir = !(out_valid && !out_ready) && !cfg_mode;
            n_cmp++; if (in_ready !== exp_ir) begin n_fail++; $display("FAIL in_ready cyc %0d got %b want %b", cyc, in_ready, exp_ir); end
            if (in_valid && in_ready) begin q.push_back(model(in_sample, nd)); sent++; end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra cyc %0d node %b", cyc, out_node);
                end else begin
                    e = q.pop_front();
                    if (out_node !== e.node || out_miss !== e.miss || out_sample !== e.sample) begin
                        n_fail++; $display("FAIL stream_data #%0d got %b/%b want %b/%b", got, out_node, out_miss, e.node, e.miss);
                    end
                end
                got++;
            end
            was_stall = out_valid && !out_ready;
            held.node = out_node; held.miss = out_miss; held.sample = out_sample;
            tick(); cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got !== n) begin n_fail++; $display("FAIL stream_count got %0d want %0d", got, n); end
        for (int c = 0; c < LAT + 2; c++) begin if (out_valid) extra = 1'b1; tick(); end
        n_cmp++; if (extra !== 1'b0 || q.size() != 0) begin n_fail++; $display("FAIL stream_leftover out %b queue %0d want 0/0", extra, q.size()); end
    endtask

    task automatic test_overwrite();
        int lat; logic [STAGE:0] on; logic om; logic [SW-1:0] os;
        cfg_mode = 1'b1; #1;
        do_write(3, 2, 32'd1000);
        do_write(3, 2, 32'd10);
        cfg_mode = 1'b0; tick();
        m_fsel[3] = 2; m_thr[3] = 32'd10; m_valid[3] = 1'b1;
        send_one(with_feat(2, 32'd500), 3, lat, on, om, os);
        n_cmp++; if (on !== 3'b111 || om !== 1'b0) begin n_fail++; $display("FAIL overwrite got %b/%b want 111/0", on, om); end
    endtask

`ifdef TREE_STAGE_PERF_CNT_EN
    task automatic test_perf();
        int lat; logic [STAGE:0] on; logic om; logic [SW-1:0] os;
        cfg_mode = 1'b1; #1;
        do_write(0, 0, 32'd50);
        cfg_mode = 1'b0; tick();
        n_cmp++; if (perf_samples !== 32'd0) begin n_fail++; $display("FAIL perf_clear got %0d want 0", perf_samples); end
        for (int i = 0; i < 6; i++) begin
            send_one(with_feat(0, (i < 4) ? 32'd200 : 32'd10), 0, lat, on, om, os);
        end
        n_cmp++; if (perf_samples !== 32'd6) begin n_fail++; $display("FAIL perf_samples got %0d want 6", perf_samples); end
        n_cmp++; if (perf_right !== 32'd4) begin n_fail++; $display("FAIL perf_right got %0d want 4", perf_right); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin m_fsel[i] = 0; m_thr[i] = '0; m_valid[i] = 1'b0; end
        test_reset();
        test_unprogrammed();
        test_config_compare();
        test_write_busy();
        test_reset_midflight();
        program_random();
        test_stream(40, 1'b0);
        test_stream(10, 1'b1);
        test_overwrite();
`ifdef TREE_STAGE_PERF_CNT_EN
        test_perf();
`endif
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
